// File: rtl/pipe_stage_chain_if.sv
// Handshake/payload bundle for pipe_stage_chain: upstream input, downstream output,
// per-stage control hooks, hazard-scan vectors and perf counters.
interface pipe_stage_chain_if #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [TAG_W-1:0]       in_tag;
  logic                   in_allowin;
  logic [DEPTH-1:0]       ready_go;
  logic [DEPTH-1:0]       flush;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [TAG_W-1:0]       out_tag;
  logic                   out_allowin;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*TAG_W-1:0] stage_tag;
  logic [31:0]            perf_fire_cnt;
  logic [31:0]            perf_stall_cnt;

  modport master (
    output in_valid, in_data, in_tag, ready_go, flush, out_allowin,
    input  in_allowin, out_valid, out_data, out_tag, stage_valid, stage_tag,
           perf_fire_cnt, perf_stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_tag, ready_go, flush, out_allowin,
    output in_allowin, out_valid, out_data, out_tag, stage_valid, stage_tag,
           perf_fire_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/allowin pipeline register chain with per-stage ready_go and flush.
// Define PIPE_CHAIN_PERF_EN to build the saturating fire/stall performance counters.
module pipe_stage_chain #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  pipe_stage_chain_if.slave bus
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];

  logic [DEPTH:0]   allow;
  logic [DEPTH-1:0] go;
  logic [DEPTH-1:0] prev_go;
  logic [WIDTH-1:0] prev_data [DEPTH];
  logic [TAG_W-1:0] prev_tag  [DEPTH];
  logic             out_valid;

  assign go = valid_q & bus.ready_go;

  // Allowin ripples back from the downstream; flush is deliberately not part of it.
  always_comb begin
    allow        = '0;
    allow[DEPTH] = bus.out_allowin;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      allow[i] = ~valid_q[i] | (bus.ready_go[i] & allow[i+1]);
    end
  end

  always_comb begin
    prev_go      = '0;
    prev_go[0]   = bus.in_valid;
    prev_data[0] = bus.in_data;
    prev_tag[0]  = bus.in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      prev_go[i]   = go[i-1];
      prev_data[i] = data_q[i-1];
      prev_tag[i]  = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.flush[i]) begin
          // The upstream hand-off still happens; the arriving entry is simply dropped.
          valid_q[i] <= 1'b0;
        end else if (allow[i]) begin
          valid_q[i] <= prev_go[i];
          if (prev_go[i]) begin
            data_q[i] <= prev_data[i];
            tag_q[i]  <= prev_tag[i];
          end
        end
      end
    end
  end

  assign out_valid       = valid_q[DEPTH-1] & bus.ready_go[DEPTH-1];
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = data_q[DEPTH-1];
  assign bus.out_tag     = tag_q[DEPTH-1];
  assign bus.in_allowin  = allow[0];
  assign bus.stage_valid = valid_q;

  always_comb begin
    bus.stage_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.stage_tag[i*TAG_W +: TAG_W] = tag_q[i];
    end
  end

`ifdef PIPE_CHAIN_PERF_EN
  logic [31:0] fire_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        out_fire;
  logic        in_stall;

  assign out_fire = out_valid & bus.out_allowin;
  assign in_stall = bus.in_valid & ~allow[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_fire && fire_cnt_q != 32'hFFFF_FFFF) begin
        fire_cnt_q <= fire_cnt_q + 32'd1;
      end
      if (in_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.perf_fire_cnt  = fire_cnt_q;
  assign bus.perf_stall_cnt = stall_cnt_q;
`else
  assign bus.perf_fire_cnt  = 32'h0;
  assign bus.perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=3, WIDTH=8, TAG_W=5): vector table,
// directed corner sequences and a randomized run against a slot-array reference model.
module tb_pipe_stage_chain;
  localparam int unsigned D = 3;
  localparam int unsigned W = 8;
  localparam int unsigned T = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_chain_if #(.DEPTH(D), .WIDTH(W), .TAG_W(T)) bus ();

  pipe_stage_chain #(.DEPTH(D), .WIDTH(W), .TAG_W(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: one slot per stage; an entry moves on when its slot is done and the next
  // slot is free or itself emptying; flush drops whatever would land in the slot.
  logic        m_v [D];
  logic [W-1:0] m_d [D];
  logic [T-1:0] m_t [D];
  int unsigned m_fire;
  int unsigned m_stall;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic [T-1:0] t;
    logic [2:0]   rg;
    logic [2:0]   fl;
    logic         oa;
    logic         e_ia;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [T-1:0] e_ot;
    logic [2:0]   e_sv;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic [T-1:0] t,
                       input logic [2:0] rg, input logic [2:0] fl, input logic oa);
    bus.in_valid    = iv;
    bus.in_data     = d;
    bus.in_tag      = t;
    bus.ready_go    = rg;
    bus.flush       = fl;
    bus.out_allowin = oa;
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
      m_t[i] = '0;
    end
    m_fire  = 0;
    m_stall = 0;
  endtask

  // Slot i can take an entry if empty, or its occupant leaves this cycle.
  function automatic logic [D:0] m_accepts();
    logic [D:0] a;
    a[D] = bus.out_allowin;
    for (int i = D - 1; i >= 0; i--) a[i] = !m_v[i] || (bus.ready_go[i] && a[i+1]);
    return a;
  endfunction

  task automatic model_step();
    logic [D:0]   a;
    logic         arr;
    logic [W-1:0] ad;
    logic [T-1:0] at;
    a = m_accepts();
    if (m_v[D-1] && bus.ready_go[D-1] && bus.out_allowin) m_fire++;
    if (bus.in_valid && !a[0]) m_stall++;
    for (int i = D - 1; i >= 0; i--) begin
      if (i == 0) begin
        arr = bus.in_valid; ad = bus.in_data; at = bus.in_tag;
      end else begin
        arr = m_v[i-1] && bus.ready_go[i-1]; ad = m_d[i-1]; at = m_t[i-1];
      end
      if (bus.flush[i]) m_v[i] = 1'b0;
      else if (a[i]) begin
        m_v[i] = arr;
        if (arr) begin m_d[i] = ad; m_t[i] = at; end
      end
    end
  endtask

  task automatic model_check();
    logic [D:0]     a;
    logic [D-1:0]   sv;
    logic [D*T-1:0] st;
    a = m_accepts();
    for (int i = 0; i < D; i++) begin
      sv[i] = m_v[i];
      st[i*T +: T] = m_t[i];
    end
    chk("m_in_allowin", {31'd0, bus.in_allowin}, {31'd0, a[0]});
    chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, m_v[D-1] & bus.ready_go[D-1]});
    chk("m_out_data", {24'd0, bus.out_data}, {24'd0, m_d[D-1]});
    chk("m_out_tag", {27'd0, bus.out_tag}, {27'd0, m_t[D-1]});
    chk("m_stage_valid", {29'd0, bus.stage_valid}, {29'd0, sv});
    chk("m_stage_tag", {17'd0, bus.stage_tag}, {17'd0, st});
`ifdef PIPE_CHAIN_PERF_EN
    chk("m_perf_fire", bus.perf_fire_cnt, m_fire);
    chk("m_perf_stall", bus.perf_stall_cnt, m_stall);
`else
    chk("m_perf_fire", bus.perf_fire_cnt, 32'h0);
    chk("m_perf_stall", bus.perf_stall_cnt, 32'h0);
`endif
  endtask

  // Inputs change at negedge; outputs are sampled 1 time unit later, well before posedge.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int drained;
    model_reset();
    drive(1'b0, '0, '0, 3'b111, 3'b000, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stage_valid", {29'd0, bus.stage_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
    chk("rst_in_allowin", {31'd0, bus.in_allowin}, 32'd1);
    chk("rst_perf_fire", bus.perf_fire_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // {iv, d, t, rg, fl, oa, e_ia, e_ov, e_od, e_ot, e_sv}
    tbl.push_back('{1'b1, 8'h01, 5'd1, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b000});
    tbl.push_back('{1'b1, 8'h02, 5'd2, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b001});
    tbl.push_back('{1'b1, 8'h03, 5'd3, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b011});
    tbl.push_back('{1'b1, 8'h04, 5'd4, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'h01, 5'd1, 3'b111});
    tbl.push_back('{1'b1, 8'h05, 5'd5, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'h02, 5'd2, 3'b111});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'h03, 5'd3, 3'b111});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'h04, 5'd4, 3'b110});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'h05, 5'd5, 3'b100});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b000});
    // Fill A0..A2, then 4 stalled cycles with A3 waiting upstream.
    tbl.push_back('{1'b1, 8'hA0, 5'd10, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 3'b000});
    tbl.push_back('{1'b1, 8'hA1, 5'd11, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 3'b001});
    tbl.push_back('{1'b1, 8'hA2, 5'd12, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 3'b011});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b1, 8'hA3, 5'd13, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 8'hA0, 5'd10, 3'b111});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'hA0, 5'd10, 3'b111});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'hA1, 5'd11, 3'b110});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'hA2, 5'd12, 3'b100});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b000});
    // Two more entries to bring the out-fire total to 10.
    tbl.push_back('{1'b1, 8'hC0, 5'd20, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b000});
    tbl.push_back('{1'b1, 8'hC1, 5'd21, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b001});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b011});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'hC0, 5'd20, 3'b110});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 8'hC1, 5'd21, 3'b100});
    tbl.push_back('{1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 3'b000});

    foreach (tbl[n]) begin
      drive(tbl[n].iv, tbl[n].d, tbl[n].t, tbl[n].rg, tbl[n].fl, tbl[n].oa);
      #1;
      chk($sformatf("tbl%0d_in_allowin", n), {31'd0, bus.in_allowin}, {31'd0, tbl[n].e_ia});
      chk($sformatf("tbl%0d_out_valid", n), {31'd0, bus.out_valid}, {31'd0, tbl[n].e_ov});
      chk($sformatf("tbl%0d_stage_valid", n), {29'd0, bus.stage_valid}, {29'd0, tbl[n].e_sv});
      if (tbl[n].e_ov) begin
        chk($sformatf("tbl%0d_out_data", n), {24'd0, bus.out_data}, {24'd0, tbl[n].e_od});
        chk($sformatf("tbl%0d_out_tag", n), {27'd0, bus.out_tag}, {27'd0, tbl[n].e_ot});
      end
      tick();
    end

`ifdef PIPE_CHAIN_PERF_EN
    chk("perf_fire_10", bus.perf_fire_cnt, 32'd10);
    chk("perf_stall_4", bus.perf_stall_cnt, 32'd4);
`else
    chk("perf_fire_off", bus.perf_fire_cnt, 32'd0);
    chk("perf_stall_off", bus.perf_stall_cnt, 32'd0);
`endif

    // Bubble squeeze: entries in stages 0 and 2, last stage stalled.
    drive(1'b1, 8'h50, 5'd6, 3'b111, 3'b000, 1'b0); tick();
    drive(1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b0); tick();
    drive(1'b1, 8'h51, 5'd7, 3'b111, 3'b000, 1'b0); tick();
    drive(1'b0, 8'h00, 5'd0, 3'b011, 3'b000, 1'b0);
    #1;
    chk("bub_sv_101", {29'd0, bus.stage_valid}, 32'b101);
    chk("bub_in_allowin", {31'd0, bus.in_allowin}, 32'd1);
    tick();
    #1;
    chk("bub_sv_110", {29'd0, bus.stage_valid}, 32'b110);
    chk("bub_out_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1);
    drained = 0;
    for (int k = 0; k < 8 && !drained; k++) begin
      tick();
      if (bus.stage_valid == '0) drained = 1;
    end
    chk("bub_drain", drained, 32'd1);

    // Flush 3'b011 while stage 1 hands off: B1 survives into stage 2, B0 and B3 are killed.
    drive(1'b1, 8'hB2, 5'd18, 3'b111, 3'b000, 1'b0); tick();
    drive(1'b1, 8'hB1, 5'd17, 3'b111, 3'b000, 1'b0); tick();
    drive(1'b1, 8'hB0, 5'd16, 3'b111, 3'b000, 1'b0); tick();
    drive(1'b1, 8'hB3, 5'd19, 3'b111, 3'b011, 1'b1);
    #1;
    chk("fl_out_data_b2", {24'd0, bus.out_data}, 32'hB2);
    chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 5'd0, 3'b111, 3'b000, 1'b1);
    #1;
    chk("fl_sv_100", {29'd0, bus.stage_valid}, 32'b100);
    chk("fl_out_data_b1", {24'd0, bus.out_data}, 32'hB1);
    tick();
    #1;
    chk("fl_sv_000", {29'd0, bus.stage_valid}, 32'b000);

    // Asynchronous reset mid-stream.
    drive(1'b1, 8'h70, 5'd3, 3'b111, 3'b000, 1'b0); tick();
    drive(1'b1, 8'h71, 5'd4, 3'b111, 3'b000, 1'b0); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_stage_valid", {29'd0, bus.stage_valid}, 32'd0);
    chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ar_perf_fire", bus.perf_fire_cnt, 32'd0);
    chk("ar_perf_stall", bus.perf_stall_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic [2:0] rg;
      logic [2:0] fl;
      for (int b = 0; b < 3; b++) begin
        rg[b] = ($urandom_range(0, 3) != 0);
        fl[b] = ($urandom_range(0, 9) == 0);
      end
      drive(1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom), rg, fl,
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
